prince_sbox_cms_pipe: RTL and testbench
=======================================

// Module: prince_sbox_cms_pipe
// PURPOSE
// - First-order CMS-masked PRINCE S-box layer: NSBOX parallel nibbles, 2 input / 2 output shares.
// - Two register stages:
//   - Stage 1 evaluates the expanded cubic share functions and registers them.
//   - Stage 2 compresses with fresh-mask refresh and registers the result.
// - Valid/ready pipeline between the key-add/state register and the linear layer of the masked PRINCE core.
//
// PARAMETERS
// NSBOX     16   number of 4-bit S-boxes in parallel (state width 4*NSBOX)
// RND_W     12   fresh random bits per S-box per accepted input
// EXP_SH    8    expanded shares per output bit after stage 1 (2 input shares, cubic -> 2^3)
//
// PORTS
// clk        in   1             clock, rising edge
// rst        in   1             synchronous, active-high reset
// in_valid   in   1             input shares and rnd valid
// in_ready   out  1             pipeline accepts input this cycle
// in_sh0     in   4*NSBOX       share 0 of state
// in_sh1     in   4*NSBOX       share 1 of state
// rnd        in   RND_W*NSBOX   fresh randomness, sampled only on accept
// out_valid  out  1             output shares valid
// out_ready  in   1             consumer takes output this cycle
// out_sh0    out  4*NSBOX       share 0 of S-box output
// out_sh1    out  4*NSBOX       share 1 of S-box output
//
// BEHAVIOUR
// - One clock (clk). Reset is synchronous, active-high (rst).
// - Reset clears s1_valid, s2_valid, all expanded-share registers and both output share registers to 0.
// - After reset: in_ready=1, out_valid=0.
// - Correctness: for each nibble i, out_sh0[i]^out_sh1[i] == S(in_sh0[i]^in_sh1[i]).
//   - S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4} (index 0..F).
// - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
// - Stage 1 (on accept):
//   - Each expanded share function uses at most one share index per input variable (non-completeness).
//   - rnd is XORed in a zero-sum pattern over the EXP_SH shares of each output bit, then registered.
// - Stage 2: XOR-compresses the EXP_SH shares of each bit into 2 output shares and registers them.
//   - No combinational path from stage-1 inputs to outputs.
// - Latency: exactly 2 cycles accept->out_valid when out_ready is held 1. Throughput: 1 per cycle.
// - Stall rules:
//   - s2_adv = !s2_valid | out_ready.
//   - s1_adv = !s1_valid | s2_adv.
//   - in_ready = s1_adv, driven combinationally from out_ready; no skid buffer.
// - Hold: when a stage does not advance, its data and valid are held bit-exact.
//   - out_sh0/out_sh1 stay stable while out_valid & !out_ready.
// - Simultaneous accept and deliver with a full pipe: both happen, no bubble, no loss.
// - Empty stage: its registers keep the last data; valid=0. No zeroing, to limit glitch transitions.
// - rst mid-operation: all in-flight data is discarded and valids clear next edge; rnd sampled that cycle is dropped.
// - Uncorrelated rnd per accept is the caller's duty. The block never reuses rnd.
//
// CONFIGURATION
// - SBOX_INV_EN defined:
//   - Adds port `inv  in  1`, sampled on accept and carried down the pipe alongside valid.
//   - inv=1 selects S^-1 = {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1}.
//   - Mode is per transaction; mixed modes may be in flight together.
// - SBOX_INV_EN undefined: no inv port; forward S only; area of the inverse share functions removed.
//
// TESTING
// - Reset: rst=1 2 cycles -> in_ready=1, out_valid=0, out_sh0=out_sh1=0.
// - Streaming, out_ready=1:
//   - Accept x=0..F in all nibbles, in_sh1=random, rnd=random.
//   - Required: out_valid 2 cycles later; recombined out per nibble = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4; no gaps.
// - Backpressure:
//   - Fill the pipe, drop out_ready 3 cycles.
//   - Required: in_ready=0 once both stages are full; outputs bit-stable; no loss or duplication on release.
// - Simultaneous events: full pipe with in_valid=out_ready=1 each cycle -> one accept and one deliver per cycle.
// - Reset mid-flight: rst with 2 items in flight -> out_valid=0 next cycle; those items never appear.
// - SBOX_INV_EN: inv=1, x=0 -> recombined B; x=4 -> F. Alternating inv per cycle -> each result matches its own mode.

Source files
------------

// File: rtl/prince_sbox_cms_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prince_sbox_cms_pipe
// Description : First-order CMS-masked PRINCE S-box layer. NSBOX nibbles in
//               parallel, 2 input shares -> 8 expanded shares per output bit
//               (stage 1, registered) -> 2 output shares (stage 2, registered).
//               Valid/ready handshake, no skid buffer.
//               Optional macro SBOX_INV_EN adds an 'inv' port that selects the
//               inverse S-box per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module prince_sbox_cms_pipe #(
    parameter int NSBOX  = 16,
    parameter int RND_W  = 12,
    parameter int EXP_SH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NSBOX-1:0]     in_sh0,
    input  logic [4*NSBOX-1:0]     in_sh1,
    input  logic [RND_W*NSBOX-1:0] rnd,
`ifdef SBOX_INV_EN
    input  logic                   inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NSBOX-1:0]     out_sh0,
    output logic [4*NSBOX-1:0]     out_sh1
);

    // S-box lookup tables, entry x at bits [4x+3:4x]
    localparam logic [63:0] C_SBOX_FWD = 64'h4D5E087619CA23FB;

    // Share e reads input share index vec[v] for variable x_v. The four-bit
    // vectors are the even-parity words, so any three variables see all eight
    // share-index combinations exactly once: every cubic cross term has one
    // home, and no share function ever sees both shares of one variable.
    function automatic logic [3:0] share_var_sel(input logic [2:0] e);
        return {^e, e};
    endfunction

    // Output of expanded share function e for the four share bits y it reads.
    // Each ANF monomial's cross product lands in the lowest-numbered share
    // whose index vector matches on the monomial's variables.
    function automatic logic [3:0] share_fn(input logic [63:0] tbl,
                                            input logic [2:0]  e,
                                            input logic [3:0]  y);
        logic [3:0][15:0] anf;
        logic [3:0]       f;
        logic [3:0]       ve;
        logic [3:0]       m;
        logic             own;
        f   = '0;
        anf = '0;
        ve  = share_var_sel(e);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 16; k++) anf[b][k] = tbl[4*k + b];
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 16; k++) begin
                    if (((k >> i) & 1) != 0) anf[b][k] = anf[b][k] ^ anf[b][k ^ (1 << i)];
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            m   = 4'(k);
            own = 1'b1;
            for (int e2 = 0; e2 < 8; e2++) begin
                if (e2 < int'(e) && ((share_var_sel(3'(e2)) & m) == (ve & m))) own = 1'b0;
            end
            if (own && ((m & ~y) == 4'b0000)) begin
                for (int b = 0; b < 4; b++) f[b] = f[b] ^ anf[b][k];
            end
        end
        return f;
    endfunction

    // Concatenated truth tables of all eight share functions: {e, y, bit}
    function automatic logic [511:0] mk_share_tables(input logic [63:0] tbl);
        logic [511:0] t;
        t = '0;
        for (int e = 0; e < 8; e++) begin
            for (int y = 0; y < 16; y++) begin
                t[(e*16 + y)*4 +: 4] = share_fn(tbl, 3'(e), 4'(y));
            end
        end
        return t;
    endfunction

    localparam logic [511:0] C_FWD_SHARES = mk_share_tables(C_SBOX_FWD);

    logic [511:0] share_tbl;
`ifdef SBOX_INV_EN
    localparam logic [63:0]  C_SBOX_INV   = 64'h1CE5046A98DF237B;
    localparam logic [511:0] C_INV_SHARES = mk_share_tables(C_SBOX_INV);
    assign share_tbl = inv ? C_INV_SHARES : C_FWD_SHARES;
`else
    assign share_tbl = C_FWD_SHARES;
`endif

    // Pipeline state
    logic                                 s1_valid_q;
    logic                                 s2_valid_q;
    logic [NSBOX-1:0][3:0][EXP_SH-1:0]    exp_d;
    logic [NSBOX-1:0][3:0][EXP_SH-1:0]    exp_q;
    logic [4*NSBOX-1:0]                   out_sh0_d;
    logic [4*NSBOX-1:0]                   out_sh1_d;
    logic [4*NSBOX-1:0]                   out_sh0_q;
    logic [4*NSBOX-1:0]                   out_sh1_q;
    logic                                 s1_adv;
    logic                                 s2_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_sh0   = out_sh0_q;
    assign out_sh1   = out_sh1_q;

    // Stage-1 next state: expanded share functions plus zero-sum refresh.
    // Random bit k of each output bit masks shares k and 4+k, so both output
    // halves are refreshed while the total over all eight shares is unchanged.
    always_comb begin
        logic [3:0] sel;
        logic [3:0] y;
        logic [3:0] f;
        logic       r;
        exp_d = '0;
        sel   = '0;
        y     = '0;
        f     = '0;
        r     = 1'b0;
        for (int i = 0; i < NSBOX; i++) begin
            for (int e = 0; e < EXP_SH; e++) begin
                sel = share_var_sel(3'(e));
                for (int v = 0; v < 4; v++) begin
                    y[v] = sel[v] ? in_sh1[4*i + v] : in_sh0[4*i + v];
                end
                f = share_tbl[{3'(e), y, 2'b00} +: 4];
                for (int b = 0; b < 4; b++) exp_d[i][b][e] = f[b];
            end
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < 3; k++) begin
                    r = rnd[RND_W*i + 3*b + k];
                    exp_d[i][b][k]     = exp_d[i][b][k] ^ r;
                    exp_d[i][b][4 + k] = exp_d[i][b][4 + k] ^ r;
                end
            end
        end
    end

    // Stage-2 next state: XOR-compress each half of the expanded shares
    always_comb begin
        out_sh0_d = '0;
        out_sh1_d = '0;
        for (int i = 0; i < NSBOX; i++) begin
            for (int b = 0; b < 4; b++) begin
                out_sh0_d[4*i + b] = ^exp_q[i][b][EXP_SH/2-1:0];
                out_sh1_d[4*i + b] = ^exp_q[i][b][EXP_SH-1:EXP_SH/2];
            end
        end
    end

    // Stage 1 register: capture on accept, hold while stalled, keep data when emptied
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            exp_q      <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) exp_q <= exp_d;
        end
    end

    // Stage 2 register: load compressed shares when stage 1 hands over
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            out_sh0_q  <= '0;
            out_sh1_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sh0_q <= out_sh0_d;
                out_sh1_q <= out_sh1_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prince_sbox_cms_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_prince_sbox_cms_pipe
// Description : Self-checking bench for prince_sbox_cms_pipe: table-lookup
//               reference model, in-order scoreboard, directed handshake
//               checks. Define SBOX_INV_EN to also exercise the inverse mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prince_sbox_cms_pipe;

    localparam int NSBOX  = 16;
    localparam int RND_W  = 12;
    localparam int EXP_SH = 8;

    localparam logic [3:0] SF [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                      4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] SI [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                      4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NSBOX-1:0]     in_sh0;
    logic [4*NSBOX-1:0]     in_sh1;
    logic [RND_W*NSBOX-1:0] rnd;
    logic                   inv_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NSBOX-1:0]     out_sh0;
    logic [4*NSBOX-1:0]     out_sh1;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic lat_chk;

    logic [63:0] q_exp [$];
    int          q_cyc [$];
    logic [63:0] sb_e;
    int          sb_c;
    logic [63:0] hold0;
    logic [63:0] hold1;

    prince_sbox_cms_pipe #(
        .NSBOX  (NSBOX),
        .RND_W  (RND_W),
        .EXP_SH (EXP_SH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .rnd       (rnd),
`ifdef SBOX_INV_EN
        .inv       (inv_b),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] sbox_ref(input logic [63:0] x, input logic md);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = md ? SI[x[4*i +: 4]] : SF[x[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] x, input logic md);
        logic [63:0] m;
        m        = {$urandom, $urandom};
        in_valid = v;
        in_sh1   = m;
        in_sh0   = m ^ x;
        for (int w = 0; w < 6; w++) rnd[w*32 +: 32] = $urandom;
        inv_b    = md;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q_exp.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(q_exp.size()), 0);
        chk("drain_out_valid", out_valid, 0);
        next_cycle();
    endtask

    // Scoreboard: in-order expected results, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            q_cyc.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("sb_spurious_output", out_sh0 ^ out_sh1, '1);
                end else begin
                    sb_e = q_exp.pop_front();
                    sb_c = q_cyc.pop_front();
                    chk("sb_data", out_sh0 ^ out_sh1, sb_e);
                    if (lat_chk) chk("sb_latency", 64'(cyc - sb_c), 2);
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(sbox_ref(in_sh0 ^ in_sh1, inv_b));
                q_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inv_b = 1'b0; lat_chk = 1'b0;
        in_sh0 = '0; in_sh1 = '0; rnd = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sh0", out_sh0, 0);
        chk("rst_out_sh1", out_sh1, 0);
        next_cycle();
        rst = 1'b0;
        lat_chk = 1'b1;

        // Streaming x = 0..F in all nibbles, out_ready held high
        for (int x = 0; x < 16; x++) begin
            drive(1'b1, {16{4'(x)}}, 1'b0);
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            chk("stream_out_valid", out_valid, 64'(x >= 2));
            if (x >= 2) chk("stream_value", out_sh0 ^ out_sh1, {16{SF[x-2]}});
            next_cycle();
        end
        lat_chk = 1'b0;

        // Backpressure with both stages full
        out_ready = 1'b0;
        drive(1'b1, {$urandom, $urandom}, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        hold0 = out_sh0;
        hold1 = out_sh1;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive(1'b1, {$urandom, $urandom}, 1'b0);
            @(negedge clk);
            chk("bp_in_ready_hold", in_ready, 0);
            chk("bp_out_sh0_stable", out_sh0, hold0);
            chk("bp_out_sh1_stable", out_sh1, hold1);
        end
        next_cycle();
        out_ready = 1'b1;

        // Full pipe: one accept and one deliver every cycle
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b0);
            @(negedge clk);
            chk("sim_in_ready", in_ready, 1);
            chk("sim_out_valid", out_valid, 1);
            next_cycle();
        end

        // Random traffic with random stalls
        for (int k = 0; k < 80; k++) begin
`ifdef SBOX_INV_EN
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
`else
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'b0);
`endif
            out_ready = 1'($urandom_range(0, 2) != 0);
            next_cycle();
        end
        drain();

        // Reset with two items in flight
        out_ready = 1'b0;
        drive(1'b1, {$urandom, $urandom}, 1'b0);
        next_cycle();
        drive(1'b1, {$urandom, $urandom}, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_out_sh0", out_sh0, 0);
        chk("rstmid_out_sh1", out_sh1, 0);
        chk("rstmid_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            chk("rstmid_no_ghost", out_valid, 0);
        end
        next_cycle();

`ifdef SBOX_INV_EN
        // Inverse mode: x=0 -> B, x=4 -> F, then alternating modes
        drive(1'b1, 64'h0, 1'b1);
        next_cycle();
        drive(1'b1, {16{4'h4}}, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("inv_x0", out_sh0 ^ out_sh1, {16{4'hB}});
        next_cycle();
        @(negedge clk);
        chk("inv_x4", out_sh0 ^ out_sh1, {16{4'hF}});
        next_cycle();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, {$urandom, $urandom}, 1'(k % 2));
            next_cycle();
        end
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
